// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl: 4-digit passcode FSM with timed unlock, error and lockout states
// ports: clk, rst_n (async active-low); num_h digit code (>9 = none), enter/clr/set_pw key levels;
// unlock/err/alarm Moore flags, state code, entry_cnt/entry_digits entry buffer, fail_cnt failures.
// define PWCHG_EN to allow storing a new password from OPEN via set_pw.
module doorlock_ctrl #(
  parameter logic [15:0] DEFAULT_PW  = 16'h1234,
  parameter int unsigned OPEN_CYCLES = 50000000,
  parameter int unsigned ERR_CYCLES  = 25000000,
  parameter int unsigned LOCK_CYCLES = 500000000,
  parameter int unsigned MAX_FAIL    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  num_h,
  input  logic        enter,
  input  logic        clr,
  input  logic        set_pw,
  output logic        unlock,
  output logic        err,
  output logic        alarm,
  output logic [2:0]  state,
  output logic [2:0]  entry_cnt,
  output logic [15:0] entry_digits,
  output logic [1:0]  fail_cnt
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    CHECK = 3'd2,
    OPEN  = 3'd3,
    FAIL  = 3'd4,
    LOCK  = 3'd5
  } state_t;
  state_t st, st_n;
  logic [31:0] tmr, tmr_n;
  logic [3:0] num_q;
  logic enter_q, clr_q;
  logic [2:0] cnt_n, sh_cnt;
  logic [15:0] dig_n, sh_dig, pw;
  logic [1:0] fail_n;
  logic dig_ev, enter_ev, clr_ev, full, match;
`ifdef PWCHG_EN
  logic set_q, set_ev, store;
  logic [15:0] pw_n;
  assign set_ev = set_pw & ~set_q;
  assign store = set_ev & full & ~clr_ev;
`else
  logic unused;
  assign unused = set_pw;
  assign pw = DEFAULT_PW;
`endif
  // a digit counts only when the previous cycle showed no key, so a held key or a slide between keys is one/no event
  assign dig_ev = num_q > 4'd9 && num_h <= 4'd9;
  assign enter_ev = enter & ~enter_q;
  assign clr_ev = clr & ~clr_q;
  assign full = entry_cnt == 3'd4;
  assign match = full && entry_digits == pw;
  assign sh_cnt = entry_cnt + 3'd1;
  assign sh_dig = {entry_digits[11:0], num_h};
  assign state = st;
  assign unlock = st == OPEN;
  assign err = st == FAIL;
  assign alarm = st == LOCK;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      tmr <= '0;
      num_q <= 4'hA;
      enter_q <= 1'b0;
      clr_q <= 1'b0;
      entry_cnt <= '0;
      entry_digits <= '0;
      fail_cnt <= '0;
`ifdef PWCHG_EN
      set_q <= 1'b0;
      pw <= DEFAULT_PW;
`endif
    end else begin
      st <= st_n;
      tmr <= tmr_n;
      num_q <= num_h;
      enter_q <= enter;
      clr_q <= clr;
      entry_cnt <= cnt_n;
      entry_digits <= dig_n;
      fail_cnt <= fail_n;
`ifdef PWCHG_EN
      set_q <= set_pw;
      pw <= pw_n;
`endif
    end
  end
  always_comb begin
    st_n = st;
    tmr_n = tmr;
    cnt_n = entry_cnt;
    dig_n = entry_digits;
    fail_n = fail_cnt;
`ifdef PWCHG_EN
    pw_n = pw;
`endif
    case (st)
      IDLE: begin
        if (dig_ev) begin
          st_n = ENTRY;
          cnt_n = 3'd1;
          dig_n = {12'h0, num_h};
        end
      end
      ENTRY: begin
        if (clr_ev) begin
          st_n = IDLE;
          cnt_n = '0;
          dig_n = '0;
        end else if (enter_ev) begin
          st_n = CHECK;
        end else if (dig_ev && !full) begin
          cnt_n = sh_cnt;
          dig_n = sh_dig;
        end
      end
      CHECK: begin
        cnt_n = '0;
        dig_n = '0;
        if (match) begin
          st_n = OPEN;
          fail_n = '0;
          tmr_n = OPEN_CYCLES - 1;
        end else if (32'(fail_cnt) + 32'd1 == MAX_FAIL) begin
          st_n = LOCK;
          tmr_n = LOCK_CYCLES - 1;
        end else begin
          st_n = FAIL;
          fail_n = fail_cnt + 2'd1;
          tmr_n = ERR_CYCLES - 1;
        end
      end
      OPEN: begin
        tmr_n = tmr - 32'd1;
`ifdef PWCHG_EN
        // a store in the final open cycle still lands, so the key beats the timeout
        if (clr_ev || store || tmr == '0) begin
          st_n = IDLE;
          tmr_n = '0;
          cnt_n = '0;
          dig_n = '0;
          pw_n = store ? entry_digits : pw;
        end else if (dig_ev && !full) begin
          cnt_n = sh_cnt;
          dig_n = sh_dig;
        end
`else
        if (clr_ev || tmr == '0) begin
          st_n = IDLE;
          tmr_n = '0;
        end
`endif
      end
      FAIL: begin
        tmr_n = tmr - 32'd1;
        if (tmr == '0) begin
          st_n = IDLE;
          tmr_n = '0;
        end
      end
      LOCK: begin
        tmr_n = tmr - 32'd1;
        if (tmr == '0) begin
          st_n = IDLE;
          tmr_n = '0;
          fail_n = '0;
        end
      end
      default: st_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_doorlock_ctrl.sv
// tb_doorlock_ctrl: table-driven plus directed corner sequences for doorlock_ctrl
module tb_doorlock_ctrl;
  logic clk, rst_n, enter, clr, set_pw;
  logic [3:0] num_h;
  logic unlock, err, alarm;
  logic [2:0] state, entry_cnt;
  logic [15:0] entry_digits;
  logic [1:0] fail_cnt;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [3:0] n;
    logic e;
    logic c;
    logic [2:0] st;
    logic [2:0] cnt;
    logic [15:0] dig;
    logic ul;
  } vec_t;
  vec_t tv[32];
  int nv = 0;
  doorlock_ctrl #(
    .DEFAULT_PW(16'h1234),
    .OPEN_CYCLES(8),
    .ERR_CYCLES(4),
    .LOCK_CYCLES(16),
    .MAX_FAIL(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .num_h(num_h),
    .enter(enter),
    .clr(clr),
    .set_pw(set_pw),
    .unlock(unlock),
    .err(err),
    .alarm(alarm),
    .state(state),
    .entry_cnt(entry_cnt),
    .entry_digits(entry_digits),
    .fail_cnt(fail_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic cyc(input logic [3:0] n, input logic e, input logic c, input logic s);
    num_h = n;
    enter = e;
    clr = c;
    set_pw = s;
    @(posedge clk);
    #1;
  endtask
  task automatic key(input logic [3:0] d);
    cyc(d, 1'b0, 1'b0, 1'b0);
    cyc(4'hA, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic code(input logic [15:0] c, input int n);
    for (int i = 0; i < n; i++) key(c[15-4*i -: 4]);
  endtask
  task automatic submit;
    cyc(4'hA, 1'b1, 1'b0, 1'b0);
    chk("check_state", 16'(state), 16'd2);
    cyc(4'hA, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'hA, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic add(input logic [3:0] n, input logic e, input logic c, input logic [2:0] st,
                     input logic [2:0] cnt, input logic [15:0] dig, input logic ul);
    tv[nv].n = n;
    tv[nv].e = e;
    tv[nv].c = c;
    tv[nv].st = st;
    tv[nv].cnt = cnt;
    tv[nv].dig = dig;
    tv[nv].ul = ul;
    nv++;
  endtask
  initial begin
    for (int i = 0; i < 10; i++) add(4'h7, 0, 0, 3'd1, 3'd1, 16'h0007, 0);
    add(4'h2, 0, 0, 3'd1, 3'd1, 16'h0007, 0);
    add(4'hA, 0, 0, 3'd1, 3'd1, 16'h0007, 0);
    add(4'hA, 0, 1, 3'd0, 3'd0, 16'h0000, 0);
    add(4'hA, 0, 0, 3'd0, 3'd0, 16'h0000, 0);
    add(4'h1, 0, 0, 3'd1, 3'd1, 16'h0001, 0);
    add(4'hA, 0, 0, 3'd1, 3'd1, 16'h0001, 0);
    add(4'h2, 0, 0, 3'd1, 3'd2, 16'h0012, 0);
    add(4'hA, 0, 0, 3'd1, 3'd2, 16'h0012, 0);
    add(4'h3, 0, 0, 3'd1, 3'd3, 16'h0123, 0);
    add(4'hA, 0, 0, 3'd1, 3'd3, 16'h0123, 0);
    add(4'h4, 0, 0, 3'd1, 3'd4, 16'h1234, 0);
    add(4'hA, 0, 0, 3'd1, 3'd4, 16'h1234, 0);
    add(4'h9, 0, 0, 3'd1, 3'd4, 16'h1234, 0);
    add(4'hA, 0, 0, 3'd1, 3'd4, 16'h1234, 0);
    add(4'hA, 1, 0, 3'd2, 3'd4, 16'h1234, 0);
    add(4'hA, 0, 0, 3'd3, 3'd0, 16'h0000, 1);
    add(4'hA, 0, 1, 3'd0, 3'd0, 16'h0000, 0);
    add(4'hA, 0, 0, 3'd0, 3'd0, 16'h0000, 0);
    rst_n = 1'b0;
    idle(2);
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_unlock", 16'(unlock), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_alarm", 16'(alarm), 16'd0);
    chk("rst_cnt", 16'(entry_cnt), 16'd0);
    chk("rst_digits", entry_digits, 16'h0000);
    chk("rst_fail", 16'(fail_cnt), 16'd0);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < nv; i++) begin
      cyc(tv[i].n, tv[i].e, tv[i].c, 1'b0);
      chk($sformatf("vec%0d_state", i), 16'(state), 16'(tv[i].st));
      chk($sformatf("vec%0d_cnt", i), 16'(entry_cnt), 16'(tv[i].cnt));
      chk($sformatf("vec%0d_digits", i), entry_digits, tv[i].dig);
      chk($sformatf("vec%0d_unlock", i), 16'(unlock), 16'(tv[i].ul));
    end
    code(16'h1234, 4);
    chk("open_cnt", 16'(entry_cnt), 16'd4);
    submit;
    chk("open_first", 16'(unlock), 16'd1);
    for (int i = 1; i < 8; i++) begin
      idle(1);
      chk($sformatf("open_hold%0d", i), 16'(unlock), 16'd1);
    end
    idle(1);
    chk("open_end_unlock", 16'(unlock), 16'd0);
    chk("open_end_state", 16'(state), 16'd0);
    chk("open_end_fail", 16'(fail_cnt), 16'd0);
    for (int f = 1; f <= 3; f++) begin
      code(16'h1235, 4);
      submit;
      if (f < 3) begin
        chk($sformatf("fail%0d_cnt", f), 16'(fail_cnt), 16'(f));
        chk($sformatf("fail%0d_err0", f), 16'(err), 16'd1);
        for (int i = 1; i < 4; i++) begin
          idle(1);
          chk($sformatf("fail%0d_err%0d", f, i), 16'(err), 16'd1);
        end
        idle(1);
        chk($sformatf("fail%0d_done", f), 16'(err), 16'd0);
        chk($sformatf("fail%0d_idle", f), 16'(state), 16'd0);
      end else begin
        chk("lock_alarm0", 16'(alarm), 16'd1);
        chk("lock_fail", 16'(fail_cnt), 16'd2);
        for (int i = 1; i < 16; i++) begin
          case (i % 4)
            0: cyc(4'h5, 1'b0, 1'b0, 1'b0);
            1: cyc(4'hA, 1'b0, 1'b1, 1'b0);
            2: cyc(4'hA, 1'b1, 1'b0, 1'b0);
            default: cyc(4'hA, 1'b0, 1'b0, 1'b0);
          endcase
          chk($sformatf("lock_alarm%0d", i), 16'(alarm), 16'd1);
          chk($sformatf("lock_cnt%0d", i), 16'(entry_cnt), 16'd0);
        end
        idle(1);
        chk("lock_done", 16'(alarm), 16'd0);
        chk("lock_idle", 16'(state), 16'd0);
        chk("lock_fail_clr", 16'(fail_cnt), 16'd0);
      end
    end
    code(16'h1230, 3);
    submit;
    chk("short_err", 16'(err), 16'd1);
    chk("short_fail", 16'(fail_cnt), 16'd1);
    idle(4);
    chk("short_idle", 16'(state), 16'd0);
    code(16'h5600, 2);
    chk("clr_pre_cnt", 16'(entry_cnt), 16'd2);
    cyc(4'hA, 1'b0, 1'b1, 1'b0);
    chk("clr_state", 16'(state), 16'd0);
    chk("clr_cnt", 16'(entry_cnt), 16'd0);
    idle(1);
    key(4'h5);
    cyc(4'hA, 1'b1, 1'b1, 1'b0);
    chk("both_state", 16'(state), 16'd0);
    chk("both_cnt", 16'(entry_cnt), 16'd0);
    idle(1);
    chk("both_nocheck", 16'(state), 16'd0);
    code(16'h1234, 4);
    submit;
    idle(2);
    chk("rst_mid_pre", 16'(unlock), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_unlock", 16'(unlock), 16'd0);
    chk("rst_mid_state", 16'(state), 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    code(16'h1234, 4);
    submit;
    chk("rst_reopen", 16'(unlock), 16'd1);
    idle(8);
    chk("rst_reopen_idle", 16'(state), 16'd0);
    code(16'h1234, 4);
    submit;
    chk("pw_open", 16'(unlock), 16'd1);
    cyc(4'h5, 1'b0, 1'b0, 1'b0);
    cyc(4'hA, 1'b0, 1'b0, 1'b0);
    cyc(4'h6, 1'b0, 1'b0, 1'b0);
    cyc(4'hA, 1'b0, 1'b0, 1'b0);
    cyc(4'h7, 1'b0, 1'b0, 1'b0);
    cyc(4'hA, 1'b0, 1'b0, 1'b0);
    cyc(4'h8, 1'b0, 1'b0, 1'b0);
    chk("pw_last_open", 16'(unlock), 16'd1);
`ifdef PWCHG_EN
    chk("pw_entry_cnt", 16'(entry_cnt), 16'd4);
    chk("pw_entry_dig", entry_digits, 16'h5678);
`else
    chk("pw_entry_cnt", 16'(entry_cnt), 16'd0);
    chk("pw_entry_dig", entry_digits, 16'h0000);
`endif
    cyc(4'hA, 1'b0, 1'b0, 1'b1);
    chk("pw_set_state", 16'(state), 16'd0);
    chk("pw_set_cnt", 16'(entry_cnt), 16'd0);
    idle(1);
    code(16'h1234, 4);
    submit;
`ifdef PWCHG_EN
    chk("pw_old_err", 16'(err), 16'd1);
`else
    chk("pw_old_open", 16'(unlock), 16'd1);
`endif
    idle(8);
    chk("pw_old_idle", 16'(state), 16'd0);
    code(16'h5678, 4);
    submit;
`ifdef PWCHG_EN
    chk("pw_new_open", 16'(unlock), 16'd1);
`else
    chk("pw_new_err", 16'(err), 16'd1);
`endif
    idle(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
